dmem_responder: RTL
===================

# dmem_responder

Data-memory responder at the far end of the MEM stage's memory request interface. It accepts the MEM stage's read/write enables, ALU-computed address and store data, and services each access with a fixed programmable wait-state count. While an access is outstanding it drives `freeze`, which halts the upstream pipeline. When the access is done it returns load data with a one-cycle `ready` pulse.

## Interface
- `WAIT_CYCLES`, default 3: extra wait states per access, range 0-15.
- `DEPTH_WORDS`, default 64: memory depth in 32-bit words, power of two.
- `BASE_ADDR`, default 1024: byte address mapped to word 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_r_en` in 1: load request, held by the requester until `ready`.
- `mem_w_en` in 1: store request, held by the requester until `ready`.
- `addr` in 32: byte address from the ALU result.
- `wdata` in 32: store data (Val_Rm).
- `rdata` out 32: load data, valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `freeze` out 1: stall to the upstream pipeline stages.

## Operation
- Word index = `((addr - BASE_ADDR) >> 2)` truncated to log2(DEPTH_WORDS) bits.
  - `addr[1:0]` is ignored.
  - Out-of-range addresses wrap modulo the depth; no error is reported.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If `mem_r_en` or `mem_w_en` is high at a clock edge: latch `addr`, `wdata` and the op, load `cnt` with `WAIT_CYCLES`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: perform the access at that edge and go to DONE.
    - Load: register `rdata` from the array.
    - Store: write the array.
- DONE: `ready`=1 for exactly one cycle, then go to IDLE unconditionally. Requests are not sampled in DONE.
- `freeze` = (`mem_r_en` | `mem_w_en`) & ~`ready`. It is combinational from the request inputs and the `ready` state bit.
- Both enables high: treat as a store. `rdata` returns the pre-write word (read-before-write) and `ready` pulses normally.
- A request deasserted during BUSY is a protocol violation. The latched access still completes and `ready` still pulses.
- A store never changes `rdata`, except in the both-enables case above.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, `rdata`=0, `ready`=0.
  - `freeze` is combinational and equals the request OR while in reset.
  - Array contents are not reset.
- Latency: the request is first visible in cycle 0 and `ready` is high in cycle `WAIT_CYCLES`+2.
  - `freeze` is high in cycles 0 to `WAIT_CYCLES`+1 and low in cycle `WAIT_CYCLES`+2.
- `WAIT_CYCLES`=0: accepted at the end of cycle 0, access at the end of cycle 1, `ready` in cycle 2.
- Back-to-back accesses: the next request is sampled in the first IDLE cycle after DONE. Throughput is one access per `WAIT_CYCLES`+3 cycles.
- Reset mid-operation: any state returns to IDLE immediately. A store still in BUSY is not committed. `ready` drops at once.
- Store commit is visible to a load accepted in the next IDLE cycle.

## Structure
- Shared package/defines file holds:
  - The state encoding: `DM_IDLE`=2'd0, `DM_BUSY`=2'd1, `DM_DONE`=2'd2.
  - The `BASE_ADDR` default constant, shared with the MEM stage.
- One sub-module, `dmem_array`: a synchronous single-port word RAM.
  - Ports: `clk`, `we`, `idx`, `din`, `dout`.
  - Registered read-before-write, no reset.
- FSM, counter and address translation live in `dmem_responder`.

## Test plan
- **Reset:** assert `rst` mid-cycle with no request -> `rdata`=0, `ready`=0, `freeze`=0, asynchronously.
- **Store then load:** store 0xDEADBEEF at 1028, then load from 1028 with `WAIT_CYCLES`=3.
  - Store: `freeze` is high cycles 0-4 and `ready` is high in cycle 5.
  - Load: `rdata`=0xDEADBEEF with `ready` 5 cycles after the request appears.
- **Wrap and misalignment:** store 0x11 at 1024, then load from 1024+4*64+2 -> `rdata`=0x11.
- **Both enables:** array word at 1032 holds 0xA5, then drive both enables with `wdata`=0x5A.
  - `rdata`=0xA5 on that access.
  - A subsequent load from 1032 returns 0x5A.
- **Reset during a store:** assert `rst` while the store is in BUSY with `cnt`=1 -> a later load shows the old word, and no `ready` pulse follows the reset.
- **Zero wait states:** `WAIT_CYCLES`=0, back-to-back loads held continuously -> `ready` pulses in cycles 2 and 5, and `freeze` is low only in those cycles.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: state encoding, base address
// and the latched request payload.
package dmem_responder_pkg;

  localparam int unsigned DM_BASE_ADDR = 1024;
  localparam int unsigned DM_WORD_W    = 32;
  localparam int unsigned DM_CNT_W     = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic                 store;
    logic                 load;
    logic [DM_WORD_W-1:0] addr;
    logic [DM_WORD_W-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with registered read-before-write output.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DM_WORD_W-1:0]           din,
  output logic [DM_WORD_W-1:0]           dout
);

  logic [DM_WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: services each MEM-stage access after a fixed number of
// wait states, freezing the upstream pipeline until the one-cycle ready pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned BASE_ADDR   = DM_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic [DM_WORD_W-1:0] addr,
  input  logic [DM_WORD_W-1:0] wdata,
  output logic [DM_WORD_W-1:0] rdata,
  output logic                 ready,
  output logic                 freeze
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [DM_CNT_W-1:0] CNT_INIT = DM_CNT_W'(WAIT_CYCLES);

  dm_state_e            state_q, state_d;
  logic                 accept, access;
  logic [DM_CNT_W-1:0]  cnt_q;
  dm_req_t              req_q;
  logic [DM_WORD_W-1:0] addr_sel, offset;
  logic [IDX_W-1:0]     idx;
  logic [DM_WORD_W-1:0] arr_dout;
  logic                 arr_we;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DM_IDLE;
    else     state_q <= state_d;
  end

  // Next state and access strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      DM_IDLE: begin
        if (mem_r_en || mem_w_en) begin
          accept  = 1'b1;
          state_d = DM_BUSY;
        end
      end
      DM_BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = DM_DONE;
        end
      end
      DM_DONE: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // Present the incoming address while idle so the RAM output is ready by the access edge
  assign addr_sel = (state_q == DM_IDLE) ? addr : req_q.addr;
  assign offset   = addr_sel - DM_WORD_W'(BASE_ADDR);
  assign idx      = IDX_W'(offset >> 2);
  assign arr_we   = access & req_q.store;

  // Request latch, wait counter, load data and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      cnt_q <= '0;
      rdata <= '0;
      ready <= 1'b0;
    end else begin
      ready <= access;
      if (accept) begin
        req_q <= '{store: mem_w_en, load: mem_r_en, addr: addr, wdata: wdata};
        cnt_q <= CNT_INIT;
      end else if (state_q == DM_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - DM_CNT_W'(1);
      end
      if (access && req_q.load) rdata <= arr_dout;
    end
  end

  assign freeze = (mem_r_en | mem_w_en) & ~ready;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .idx (idx),
    .din (req_q.wdata),
    .dout(arr_dout)
  );

endmodule
